// File: rtl/switch_debounce_if.sv
// Switch bundle: four raw push-button inputs in, debounced levels and strobes out.
// The master drives the raw switches; the slave is the debouncer.
interface switch_debounce_if;
  logic       i_Switch_1;
  logic       i_Switch_2;
  logic       i_Switch_3;
  logic       i_Switch_4;
  logic       o_Switch_1;
  logic       o_Switch_2;
  logic       o_Switch_3;
  logic       o_Switch_4;
  logic [3:0] o_Press;
  logic [3:0] o_Release;

  modport master (
    output i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    input  o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4, o_Press, o_Release
  );

  modport slave (
    input  i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4,
    output o_Switch_1, o_Switch_2, o_Switch_3, o_Switch_4, o_Press, o_Release
  );
endinterface

// File: rtl/switch_debounce.sv
// Four-channel push-button debouncer: 2-FF synchronizer plus hold-off FSM per channel.
// Accepts a level N+3 edges after it settles; no backpressure, strobes are one cycle wide.
module switch_debounce #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_US = 10_000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  switch_debounce_if.slave  sw
);

  localparam int N_RAW = CLK_FREQ / 1_000_000 * DEBOUNCE_US;
  localparam int N     = (N_RAW < 1) ? 1 : N_RAW;
  localparam int CW    = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [3:0] raw_sw;
  logic [3:0] lvl;
  logic [3:0] press;
  logic [3:0] rel;

  assign raw_sw = {sw.i_Switch_4, sw.i_Switch_3, sw.i_Switch_2, sw.i_Switch_1};

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [1:0]    sync_q;
    logic          s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    assign s = sync_q[1];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        sync_q  <= 2'b00;
        state_q <= RELEASED;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw_sw[k]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // Any reversal during a WAIT state falls back to the stable state with cnt cleared.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == N_CNT) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == N_CNT) begin
            state_d = RELEASED;
            cnt_d   = '0;
            rel_d   = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
      lvl_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign lvl[k]   = lvl_q;
    assign press[k] = press_q;
    assign rel[k]   = rel_q;
  end

  assign sw.o_Switch_1 = lvl[0];
  assign sw.o_Switch_2 = lvl[1];
  assign sw.o_Switch_3 = lvl[2];
  assign sw.o_Switch_4 = lvl[3];
  assign sw.o_Press    = press;
  assign sw.o_Release  = rel;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with N=10, checked every cycle against a run-length model
// and at key points against hand-computed values.
module tb_switch_debounce;
  localparam int N = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   p_cnt[4];
  int   r_cnt[4];

  switch_debounce_if sw_if ();

  switch_debounce #(
    .CLK_FREQ    (1_000_000),
    .DEBOUNCE_US (10)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .sw      (sw_if)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] raw_v();
    return {sw_if.i_Switch_4, sw_if.i_Switch_3, sw_if.i_Switch_2, sw_if.i_Switch_1};
  endfunction

  function automatic logic [3:0] osw();
    return {sw_if.o_Switch_4, sw_if.o_Switch_3, sw_if.o_Switch_2, sw_if.o_Switch_1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the debounced level flips once the two-cycle-delayed input has
  // disagreed with it on N+1 consecutive edges.
  logic [3:0] m_sync1, m_s, m_lvl, m_press, m_rel;
  int         m_run[4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 <= '0;
      m_s     <= '0;
      m_lvl   <= '0;
      m_press <= '0;
      m_rel   <= '0;
      for (int k = 0; k < 4; k++) m_run[k] <= 0;
    end else begin
      m_press <= '0;
      m_rel   <= '0;
      for (int k = 0; k < 4; k++) begin
        if (m_s[k] != m_lvl[k]) begin
          if (m_run[k] == N) begin
            m_lvl[k]   <= ~m_lvl[k];
            m_press[k] <= ~m_lvl[k];
            m_rel[k]   <= m_lvl[k];
            m_run[k]   <= 0;
          end else begin
            m_run[k]   <= m_run[k] + 1;
          end
        end else begin
          m_run[k] <= 0;
        end
      end
      m_s     <= m_sync1;
      m_sync1 <= raw_v();
    end
  end

  always begin
    @(negedge clk);
    #1;
    chk("model_level",   32'(osw()),           32'(m_lvl));
    chk("model_press",   32'(sw_if.o_Press),   32'(m_press));
    chk("model_release", 32'(sw_if.o_Release), 32'(m_rel));
    for (int k = 0; k < 4; k++) begin
      if (sw_if.o_Press[k] === 1'b1)   p_cnt[k]++;
      if (sw_if.o_Release[k] === 1'b1) r_cnt[k]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw_if.i_Switch_1 = v[0];
    sw_if.i_Switch_2 = v[1];
    sw_if.i_Switch_3 = v[2];
    sw_if.i_Switch_4 = v[3];
  endtask

  initial begin
    int p0, r0, p2, r2;
    for (int k = 0; k < 4; k++) begin
      p_cnt[k] = 0;
      r_cnt[k] = 0;
    end
    rst_n = 1'b0;
    set_sw(4'hF);

    // 1: reset with all switches held
    tick(3);
    chk("rst_level",   32'(osw()),           32'h0);
    chk("rst_press",   32'(sw_if.o_Press),   32'h0);
    chk("rst_release", 32'(sw_if.o_Release), 32'h0);
    rst_n = 1'b1;
    tick(12);
    chk("t1_level_early", 32'(osw()), 32'h0);
    tick(1);
    chk("t1_level",  32'(osw()),         32'hF);
    chk("t1_press",  32'(sw_if.o_Press), 32'hF);
    tick(1);
    chk("t1_press_end", 32'(sw_if.o_Press), 32'h0);
    chk("t1_level_hold", 32'(osw()), 32'hF);

    set_sw(4'h0);
    tick(12);
    chk("t1_rel_early", 32'(osw()), 32'hF);
    tick(1);
    chk("t1_rel_level", 32'(osw()),           32'h0);
    chk("t1_release",   32'(sw_if.o_Release), 32'hF);
    tick(5);

    // 2: clean press on switch 2
    set_sw(4'b0010);
    tick(12);
    chk("t2_level_early", 32'(sw_if.o_Switch_2), 32'h0);
    tick(1);
    chk("t2_level",   32'(sw_if.o_Switch_2), 32'h1);
    chk("t2_press",   32'(sw_if.o_Press),    32'h2);
    chk("t2_release", 32'(sw_if.o_Release),  32'h0);
    tick(1);
    chk("t2_press_end", 32'(sw_if.o_Press), 32'h0);

    // 3: glitches of 5 and 10 cycles on switch 3
    p2 = p_cnt[2];
    r2 = r_cnt[2];
    set_sw(4'b0110); tick(5);
    set_sw(4'b0010); tick(15);
    set_sw(4'b0110); tick(10);
    set_sw(4'b0010); tick(20);
    chk("t3_level",     32'(sw_if.o_Switch_3), 32'h0);
    chk("t3_press_cnt", 32'(p_cnt[2] - p2),    32'h0);
    chk("t3_rel_cnt",   32'(r_cnt[2] - r2),    32'h0);

    // 4: bouncing press then bouncing release on switch 1
    p0 = p_cnt[0];
    r0 = r_cnt[0];
    sw_if.i_Switch_1 = 1'b1; tick(4);
    sw_if.i_Switch_1 = 1'b0; tick(2);
    sw_if.i_Switch_1 = 1'b1; tick(7);
    sw_if.i_Switch_1 = 1'b0; tick(1);
    sw_if.i_Switch_1 = 1'b1; tick(12);
    chk("t4_level_early", 32'(sw_if.o_Switch_1), 32'h0);
    tick(1);
    chk("t4_level",  32'(sw_if.o_Switch_1), 32'h1);
    chk("t4_press",  32'(sw_if.o_Press),    32'h1);
    tick(5);
    chk("t4_press_cnt", 32'(p_cnt[0] - p0), 32'h1);
    sw_if.i_Switch_1 = 1'b0; tick(4);
    sw_if.i_Switch_1 = 1'b1; tick(2);
    sw_if.i_Switch_1 = 1'b0; tick(7);
    sw_if.i_Switch_1 = 1'b1; tick(1);
    sw_if.i_Switch_1 = 1'b0; tick(12);
    chk("t4_rel_early", 32'(sw_if.o_Switch_1), 32'h1);
    tick(1);
    chk("t4_rel_level", 32'(sw_if.o_Switch_1), 32'h0);
    chk("t4_release",   32'(sw_if.o_Release),  32'h1);
    tick(5);
    chk("t4_rel_cnt",    32'(r_cnt[0] - r0), 32'h1);
    chk("t4_press_cnt2", 32'(p_cnt[0] - p0), 32'h1);

    // 5: reset while switch 4 is mid-debounce (cnt=6), switch 2 still pressed
    set_sw(4'b1010);
    tick(8);
    chk("t5_pre_level", 32'(osw()), 32'b0010);
    rst_n = 1'b0;
    #2;
    chk("t5_async_level",   32'(osw()),           32'h0);
    chk("t5_async_press",   32'(sw_if.o_Press),   32'h0);
    chk("t5_async_release", 32'(sw_if.o_Release), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(12);
    chk("t5_level_early", 32'(osw()), 32'h0);
    tick(1);
    chk("t5_level", 32'(osw()),         32'b1010);
    chk("t5_press", 32'(sw_if.o_Press), 32'b1010);

    // 6: release switch 1 on the same edge switch 4 is pressed
    set_sw(4'b0011);
    tick(20);
    chk("t6_setup", 32'(osw()), 32'b0011);
    set_sw(4'b1010);
    tick(12);
    chk("t6_level_early", 32'(osw()), 32'b0011);
    tick(1);
    chk("t6_release", 32'(sw_if.o_Release), 32'b0001);
    chk("t6_press",   32'(sw_if.o_Press),   32'b1000);
    chk("t6_level",   32'(osw()),           32'b1010);
    tick(1);
    chk("t6_press_end",   32'(sw_if.o_Press),   32'h0);
    chk("t6_release_end", 32'(sw_if.o_Release), 32'h0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Input-side counterpart to the LED output path: samples the four Go Board push-button switches and produces clean debounced levels plus single-cycle press/release strobes for downstream logic (counters, mode selects, LED drivers).
- Each channel has a 2-FF synchronizer, followed by an independent 4-state debounce FSM with a hold-off counter.
- Channels share only clock and reset.

Parameters:
- CLK_FREQ, 25_000_000: input clock frequency in Hz.
- DEBOUNCE_US, 10_000: required stable time in microseconds.
- Derived localparam N = CLK_FREQ/1_000_000 * DEBOUNCE_US, clamped to minimum 1.
- Counter width is $clog2(N+1).

Ports:
- i_Clk  input  1  system clock; all logic is on the rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Switch_1..i_Switch_4  input  1 each  raw asynchronous switch inputs; active-high (1 = pressed).
- o_Switch_1..o_Switch_4  output  1 each  debounced registered level.
- o_Press  output  4  one-cycle strobe on a debounced press; bit k-1 maps to switch k.
- o_Release  output  4  one-cycle strobe on a debounced release; same bit mapping.

Behaviour:
- Reset (async assert, sync release by clock edge):
  - Synchronizer flops = 0.
  - All FSMs = RELEASED.
  - Counters = 0.
  - o_Switch_* = 0, o_Press = 0, o_Release = 0.
- Synchronizer:
  - Two flops per channel. s = second-stage output.
  - The raw value set up before edge e0 appears on s after e1.
- FSM per channel. States: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: s=1 -> PRESS_WAIT, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_WAIT:
    - s=0 -> RELEASED, cnt<=0. This is glitch rejection; no strobe.
    - s=1 and cnt==N -> PRESSED, cnt<=0, press strobe fires.
    - s=1 and cnt<N -> cnt<=cnt+1.
  - PRESSED: s=0 -> RELEASE_WAIT, cnt<=1. Otherwise stay.
  - RELEASE_WAIT:
    - s=1 -> PRESSED, cnt<=0; no strobe.
    - s=0 and cnt==N -> RELEASED, cnt<=0, release strobe fires.
    - Otherwise cnt<=cnt+1.
- Output definitions:
  - o_Switch_k is registered; it is 1 while the FSM is in PRESSED or RELEASE_WAIT.
  - o_Press[k-1] is high for exactly the one cycle following the edge that enters PRESSED from PRESS_WAIT.
  - o_Release[k-1] is the same, for entry into RELEASED from RELEASE_WAIT.
  - o_Switch_k changes on that same edge.
- Latency:
  - A raw input stable from before e0 is accepted at edge e(N+2).
  - o_Switch_k and the strobe are visible after e(N+2).
  - Total is N+3 edges counted from e0.
- Rejection: any excursion with s held for N or fewer cycles produces no output change and no strobe.
- Bounce: every reversal of s during a WAIT state restarts the debounce from the stable state; cnt is never carried over.
- Strobes:
  - o_Press and o_Release are never both high on the same bit.
  - At most one strobe fires per accepted transition.
  - Back-to-back strobes on one bit are impossible; the minimum spacing is N+1 cycles.
- Channels are fully independent. Simultaneous events on several channels yield simultaneous strobes on the corresponding bits.
- Reset mid-WAIT: the FSM returns to RELEASED with no strobe. If the input is still held pressed, a full new debounce is required after reset release, plus 2 synchronizer cycles.
- The counter never exceeds N, so there is no wrap.

Test Plan:
All scenarios use CLK_FREQ=1_000_000, DEBOUNCE_US=10, giving N=10.
1. Reset with i_Switch_1..4=1 held:
   - All outputs are 0 while i_Rst_n=0.
   - After release, o_Switch_1..4 rise together 13 edges later.
   - o_Press=4'b1111 for exactly 1 cycle.
2. Clean press:
   - Drive i_Switch_2 0->1, held.
   - o_Switch_2 rises after edge 13 counted from the first sampling edge.
   - o_Press=4'b0010 for 1 cycle; o_Release stays 0.
3. Glitch rejection:
   - Pulse i_Switch_3 high for 5 cycles, then for 10 cycles.
   - o_Switch_3, o_Press and o_Release stay 0 throughout.
4. Bounce:
   - On i_Switch_1 drive 1 (4 cyc), 0 (2), 1 (7), 0 (1), then 1 held.
   - Exactly one o_Press[0] pulse, 13 edges after the final rising edge.
   - Then drop to 0 with similar bounce: exactly one o_Release[0] pulse.
5. Reset mid-debounce:
   - Assert i_Rst_n=0 when cnt=6 in PRESS_WAIT, with i_Switch_4 held at 1.
   - No strobe occurs; o_Switch_4=0 immediately (async).
   - After release, o_Switch_4 rises 13 edges later.
6. Independence: channel 1 is released on the same edge that channel 4 is pressed.
   - o_Release=4'b0001 and o_Press=4'b1000 in the same cycle.
   - Channels 2 and 3 are unchanged.
